// File: rtl/cam_pkg.sv
// cam_pkg: shared defaults and typedefs for the cam_array CAM.
//   CAM_DATA_WIDTH / CAM_ADDR_WIDTH : default entry and index widths
//   cam_entry_t                     : one stored entry
//   cam_idx_t                       : entry index
package cam_pkg;

  localparam int unsigned CAM_DATA_WIDTH = 32;
  localparam int unsigned CAM_ADDR_WIDTH = 5;

  typedef logic [CAM_DATA_WIDTH-1:0] cam_entry_t;
  typedef logic [CAM_ADDR_WIDTH-1:0] cam_idx_t;

endpackage

// File: rtl/cam_cell.sv
// cam_cell: one CAM entry -- the data register, its valid bit and the
// registered equality comparator.
// Optional feature: CAM_WR_BYPASS_EN makes a same-cycle search compare
// against the post-update entry (written data / cleared valid).
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   wr_en_i, wr_data_i   write this entry (write wins over remove)
//   rm_en_i              invalidate this entry
//   search_en_i          search request
//   search_data_i        search key
//   data_o, valid_o      stored data and valid bit
//   match_o              registered match result
module cam_cell
  import cam_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = CAM_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rm_en_i,
  input  logic                  search_en_i,
  input  logic [DATA_WIDTH-1:0] search_data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  match_o
);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  match_q, match_d;
  logic [DATA_WIDTH-1:0] cmp_data;
  logic                  cmp_valid;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (rm_en_i) valid_d = 1'b0;
    if (wr_en_i) begin
      data_d  = wr_data_i;
      valid_d = 1'b1;
    end
  end

`ifdef CAM_WR_BYPASS_EN
  // Compare against the state this cycle's write/remove is about to create.
  assign cmp_data  = data_d;
  assign cmp_valid = valid_d;
`else
  assign cmp_data  = data_q;
  assign cmp_valid = valid_q;
`endif

  assign match_d = search_en_i && cmp_valid && (cmp_data == search_data_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      match_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      match_q <= match_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign match_o = match_q;

endmodule

// File: rtl/cam_array.sv
// cam_array: content-addressable memory of DEPTH entries with write,
// invalidate and 1-cycle-latency search returning a match vector.
// Optional feature: CAM_WR_BYPASS_EN (see cam_cell) lets a search see the
// same-cycle write/remove.
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   write_en_i, wr_addr_i, wr_data_i   write request
//   remove_en_i, rm_addr_i       invalidate request
//   search_en_i, search_data_i   search request and key
//   data_o                       flattened storage, entry k at [DW*(k+1)-1:DW*k]
//   written_o                    per-entry valid bits
//   match_o, match_valid_o       registered match vector and qualifier
//   count_o, full_o, empty_o     number of valid entries and its flags
module cam_array
  import cam_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = CAM_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = CAM_ADDR_WIDTH,
  parameter int unsigned DEPTH      = 1 << ADDR_WIDTH,
  parameter int unsigned SIZE       = DATA_WIDTH * DEPTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  write_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  remove_en_i,
  input  logic [ADDR_WIDTH-1:0] rm_addr_i,
  input  logic                  search_en_i,
  input  logic [DATA_WIDTH-1:0] search_data_i,
  output logic [SIZE-1:0]       data_o,
  output logic [DEPTH-1:0]      written_o,
  output logic [DEPTH-1:0]      match_o,
  output logic                  match_valid_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_CNT  = (ADDR_WIDTH+1)'(1);

  logic [DEPTH-1:0]    wr_sel;
  logic [DEPTH-1:0]    rm_sel;
  logic [DEPTH-1:0]    written;
  logic [ADDR_WIDTH:0] count_q, count_d;
  logic                match_valid_q;
  logic                inc, dec;

  for (genvar k = 0; k < DEPTH; k++) begin : g_cell
    assign wr_sel[k] = write_en_i  && (wr_addr_i == ADDR_WIDTH'(k));
    assign rm_sel[k] = remove_en_i && (rm_addr_i == ADDR_WIDTH'(k));

    cam_cell #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_cell (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .wr_en_i       (wr_sel[k]),
      .wr_data_i     (wr_data_i),
      .rm_en_i       (rm_sel[k]),
      .search_en_i   (search_en_i),
      .search_data_i (search_data_i),
      .data_o        (data_o[DATA_WIDTH*k +: DATA_WIDTH]),
      .valid_o       (written[k]),
      .match_o       (match_o[k])
    );
  end

  // Count only real transitions: a write to an already-valid entry adds
  // nothing, and a remove overridden by a same-address write removes nothing.
  assign inc = |(wr_sel & ~written);
  assign dec = |(rm_sel & ~wr_sel & written);

  always_comb begin
    count_d = count_q;
    if (inc && !dec)      count_d = count_q + ONE_CNT;
    else if (dec && !inc) count_d = count_q - ONE_CNT;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q       <= '0;
      match_valid_q <= 1'b0;
    end else begin
      count_q       <= count_d;
      match_valid_q <= search_en_i;
    end
  end

  assign written_o     = written;
  assign match_valid_o = match_valid_q;
  assign count_o       = count_q;
  assign full_o        = (count_q == FULL_CNT);
  assign empty_o       = (count_q == '0);

endmodule

// File: tb/tb_cam_array.sv
module tb_cam_array;
  import cam_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 32;
`ifdef CAM_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            we, re, se;
  logic [AW-1:0]   wa, ra;
  logic [DW-1:0]   wd, sd;
  logic [DW*N-1:0] data_o;
  logic [N-1:0]    written_o, match_o;
  logic            match_valid_o, full_o, empty_o;
  logic [AW:0]     count_o;

  cam_array #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .write_en_i    (we),
    .wr_addr_i     (wa),
    .wr_data_i     (wd),
    .remove_en_i   (re),
    .rm_addr_i     (ra),
    .search_en_i   (se),
    .search_data_i (sd),
    .data_o        (data_o),
    .written_o     (written_o),
    .match_o       (match_o),
    .match_valid_o (match_valid_o),
    .count_o       (count_o),
    .full_o        (full_o),
    .empty_o       (empty_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: plain arrays of entries and valid flags.
  logic [DW-1:0] mdata [N];
  bit            mvalid[N];
  logic [N-1:0]  mmatch;
  bit            mmv;

  function automatic int mcount();
    int c = 0;
    for (int k = 0; k < N; k++) if (mvalid[k]) c++;
    return c;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mdata[k]  = '0;
      mvalid[k] = 1'b0;
    end
    mmatch = '0;
    mmv    = 1'b0;
  endtask

  task automatic model_update(bit w, int waddr, logic [DW-1:0] wdat,
                              bit r, int raddr, bit s, logic [DW-1:0] key);
    logic [DW-1:0] ndata [N];
    bit            nvalid[N];
    ndata  = mdata;
    nvalid = mvalid;
    if (r) nvalid[raddr] = 1'b0;
    if (w) begin
      ndata[waddr]  = wdat;
      nvalid[waddr] = 1'b1;
    end
    mmatch = '0;
    for (int k = 0; k < N; k++) begin
      if (s) begin
        if (BYP) mmatch[k] = nvalid[k] && (ndata[k] == key);
        else     mmatch[k] = mvalid[k] && (mdata[k] == key);
      end
    end
    mmv    = s;
    mdata  = ndata;
    mvalid = nvalid;
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(string tag);
    logic [N-1:0] mv;
    int c;
    c = mcount();
    for (int k = 0; k < N; k++) mv[k] = mvalid[k];
    chk({tag, " written"}, 64'(written_o), 64'(mv));
    chk({tag, " match"}, 64'(match_o), 64'(mmatch));
    chk({tag, " match_valid"}, 64'(match_valid_o), 64'(mmv));
    chk({tag, " count"}, 64'(count_o), 64'(c));
    chk({tag, " full"}, 64'(full_o), 64'(c == N));
    chk({tag, " empty"}, 64'(empty_o), 64'(c == 0));
    for (int k = 0; k < N; k++)
      chk($sformatf("%s data[%0d]", tag, k), 64'(data_o[k*DW +: DW]), 64'(mdata[k]));
  endtask

  task automatic drive(bit w, int waddr, logic [DW-1:0] wdat,
                       bit r, int raddr, bit s, logic [DW-1:0] key);
    we = w; wa = AW'(waddr); wd = wdat;
    re = r; ra = AW'(raddr);
    se = s; sd = key;
  endtask

  task automatic step(string tag, bit w, int waddr, logic [DW-1:0] wdat,
                      bit r, int raddr, bit s, logic [DW-1:0] key);
    drive(w, waddr, wdat, r, raddr, s, key);
    @(posedge clk);
    model_update(w, waddr, wdat, r, raddr, s, key);
    #1;
    check_all(tag);
  endtask

  typedef struct {
    bit         w;
    int         waddr;
    cam_entry_t wdat;
    bit         r;
    int         raddr;
    bit         s;
    cam_entry_t key;
    int         exp_count;
    logic [N-1:0] exp_match;
    bit         exp_mv;
  } vec_t;

  vec_t vt[14];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    drive(0, 0, '0, 0, 0, 0, '0);
    rst = 1'b1;
    model_reset();
    #3;
    check_all("reset");
    #9 rst = 1'b0;  // t=12, between edges; first op lands on the t=15 edge

    vt[0]  = '{1, 3, 32'hDEADBEEF, 0, 0, 0, '0,           1, 32'h0, 0};
    vt[1]  = '{1, 2, 32'h12345678, 0, 0, 0, '0,           2, 32'h0, 0};
    vt[2]  = '{1, 7, 32'h12345678, 0, 0, 0, '0,           3, 32'h0, 0};
    vt[3]  = '{0, 0, '0,           0, 0, 1, 32'h12345678, 3, 32'h84, 1};
    vt[4]  = '{1, 5, 32'h55555555, 1, 5, 0, '0,           4, 32'h0, 0};
    vt[5]  = '{0, 0, '0,           1, 5, 0, '0,           3, 32'h0, 0};
    vt[6]  = '{0, 0, '0,           1, 5, 0, '0,           3, 32'h0, 0};
    vt[7]  = '{1, 3, 32'h0,        0, 0, 0, '0,           3, 32'h0, 0};
    vt[8]  = '{1, 9, 32'hA5A5A5A5, 0, 0, 1, 32'hA5A5A5A5, 4, BYP ? 32'h200 : 32'h0, 1};
    vt[9]  = '{0, 0, '0,           0, 0, 1, 32'hA5A5A5A5, 4, 32'h200, 1};
    vt[10] = '{1, 10, 32'h11111111, 1, 9, 0, '0,          4, 32'h0, 0};
    vt[11] = '{0, 0, '0,           0, 0, 1, 32'hA5A5A5A5, 4, 32'h0, 1};
    vt[12] = '{0, 0, '0,           1, 2, 1, 32'h12345678, 3, BYP ? 32'h80 : 32'h84, 1};
    vt[13] = '{1, 2, 32'h12345678, 1, 7, 1, 32'h12345678, 3, BYP ? 32'h04 : 32'h80, 1};

    for (int i = 0; i < 14; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      step(t, vt[i].w, vt[i].waddr, vt[i].wdat, vt[i].r, vt[i].raddr, vt[i].s, vt[i].key);
      chk({t, " tbl count"}, 64'(count_o), 64'(vt[i].exp_count));
      chk({t, " tbl match"}, 64'(match_o), 64'(vt[i].exp_match));
      chk({t, " tbl match_valid"}, 64'(match_valid_o), 64'(vt[i].exp_mv));
      if (i == 0) begin
        chk("vec0 entry3", 64'(data_o[127:96]), 64'h DEADBEEF);
        chk("vec0 written3", 64'(written_o[3]), 64'd1);
        chk("vec0 empty", 64'(empty_o), 64'd0);
      end
    end

    // Fill every entry, then a same-address write+remove on a full CAM.
    for (int k = 0; k < N; k++) step("fill", 1, k, 32'h01010101 * k, 0, 0, 0, '0);
    chk("fill full", 64'(full_o), 64'd1);
    chk("fill count", 64'(count_o), 64'd32);
    step("full wr+rm", 1, 0, 32'hCAFEF00D, 1, 0, 0, '0);
    chk("full wr+rm count", 64'(count_o), 64'd32);
    chk("full wr+rm entry0", 64'(data_o[31:0]), 64'hCAFEF00D);

    // Random traffic over a small key pool so matches and collisions occur.
    for (int i = 0; i < 300; i++) begin
      logic [DW-1:0] pool[4];
      pool[0] = 32'h0; pool[1] = 32'h12345678; pool[2] = 32'hA5A5A5A5; pool[3] = 32'hFFFF0000;
      step("rand", $urandom_range(0, 1) == 1, $urandom_range(0, N-1), pool[$urandom_range(0, 3)],
           $urandom_range(0, 2) != 0, $urandom_range(0, N-1),
           $urandom_range(0, 1) == 1, pool[$urandom_range(0, 3)]);
    end

    // Asynchronous reset while a search result is held and more ops are driven.
    step("pre-rst", 1, 12, 32'h12345678, 0, 0, 1, 32'h12345678);
    chk("pre-rst match_valid", 64'(match_valid_o), 64'd1);
    drive(1, 4, 32'h44444444, 1, 12, 1, 32'h12345678);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("async rst match_valid", 64'(match_valid_o), 64'd0);
    chk("async rst match", 64'(match_o), 64'd0);
    chk("async rst count", 64'(count_o), 64'd0);
    chk("async rst empty", 64'(empty_o), 64'd1);
    check_all("async rst");
    @(posedge clk);
    #1;
    check_all("rst held");
    drive(0, 0, '0, 0, 0, 0, '0);
    #3 rst = 1'b0;
    step("post-rst", 1, 4, 32'h44444444, 0, 0, 0, '0);
    chk("post-rst count", 64'(count_o), 64'd1);
    step("post-rst srch", 0, 0, '0, 0, 0, 1, 32'h44444444);
    chk("post-rst match", 64'(match_o), 64'h10);

    drive(0, 0, '0, 0, 0, 0, '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
